// File: rtl/vga_digit_display.sv
// vga_digit_display: VGA timing generator plus a bordered box of NUM_DIGITS scaled 8x8 glyphs.
// Define VGA_BLINK_EN to blink the glyph selected by cursor_idx every BLINK_FRAMES frames.
module vga_digit_display #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          NUM_DIGITS   = 8,
  parameter int          SCALE_LOG2   = 2,
  parameter int          BOX_X        = 100,
  parameter int          BOX_Y        = 50,
  parameter int          BORDER       = 5,
  parameter logic [11:0] FG_RGB       = 12'hFFF,
  parameter logic [11:0] BG_RGB       = 12'h000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic                    digit_valid,
  output logic                    digit_ready,
  input  logic [3:0]              cursor_idx,
  output logic [3:0]              out_R,
  output logic [3:0]              out_G,
  output logic [3:0]              out_B,
  output logic                    Hsync,
  output logic                    Vsync,
  output logic                    frame_start
);

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOT);
  localparam int VW       = $clog2(V_TOT);
  localparam int INNER_X  = BOX_X + BORDER;
  localparam int INNER_Y  = BOX_Y + BORDER;
  localparam int INNER_X1 = INNER_X + NUM_DIGITS * 8 * (1 << SCALE_LOG2);
  localparam int INNER_Y1 = INNER_Y + 8 * (1 << SCALE_LOG2);
  localparam int OUTER_X1 = INNER_X1 + BORDER;
  localparam int OUTER_Y1 = INNER_Y1 + BORDER;

  typedef enum logic [1:0] {
    REG_BG,
    REG_BORDER,
    REG_GLYPH
  } region_e;

  logic [HW-1:0]           r_hCnt;
  logic [VW-1:0]           r_vCnt;
  logic [31:0]             w_x;
  logic [31:0]             w_y;
  logic [31:0]             w_relX;
  logic [31:0]             w_relY;
  region_e                 w_region;
  logic [3:0]              w_digIdx;
  logic [2:0]              w_glyphRow;
  logic [2:0]              w_glyphCol;
  logic                    w_active;
  logic                    w_hSyncN;
  logic                    w_vSyncN;
  logic                    w_blank;

  region_e                 r_region1;
  logic [3:0]              r_digIdx1;
  logic [2:0]              r_row1;
  logic [2:0]              r_col1;
  logic                    r_blank1;
  logic                    r_active1;
  logic                    r_hs1;
  logic                    r_vs1;
  logic [11:0]             r_rgb;
  logic                    r_hs2;
  logic                    r_vs2;

  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_pendData;
  logic [4*NUM_DIGITS-1:0] r_shown;
  logic [3:0]              w_code;
  logic [7:0]              w_rowBits;
  logic                    w_pixel;
  logic [11:0]             w_colour;

  // Row 0 of each glyph sits in the top byte; bit 7 of a row is the leftmost column.
  function automatic logic [7:0] fontRow(input logic [3:0] code, input logic [2:0] row);
    logic [63:0] glyph;
    case (code)
      4'h0:    glyph = 64'h3C666E7666663C00;
      4'h1:    glyph = 64'h1838181818187E00;
      4'h2:    glyph = 64'h3C66060C30607E00;
      4'h3:    glyph = 64'h3C66061C06663C00;
      4'h4:    glyph = 64'h0C1C3C6C7E0C0C00;
      4'h5:    glyph = 64'h7E607C0606663C00;
      4'h6:    glyph = 64'h3C607C6666663C00;
      4'h7:    glyph = 64'h7E060C1830303000;
      4'h8:    glyph = 64'h3C66663C66663C00;
      4'h9:    glyph = 64'h3C66663E060C3800;
      4'hA:    glyph = 64'h0000007E7E000000;
      4'hB:    glyph = 64'h0018187E7E181800;
      4'hC:    glyph = 64'h00663C183C660000;
      4'hD:    glyph = 64'h02060C1830604000;
      4'hE:    glyph = 64'h007E7E007E7E0000;
      default: glyph = 64'h0;
    endcase
    return glyph[{~row, 3'b111} -: 8];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (r_hCnt == HW'(H_TOT - 1)) begin
      r_hCnt <= '0;
      r_vCnt <= (r_vCnt == VW'(V_TOT - 1)) ? '0 : r_vCnt + VW'(1);
    end else begin
      r_hCnt <= r_hCnt + HW'(1);
    end
  end

  assign w_x         = 32'(r_hCnt);
  assign w_y         = 32'(r_vCnt);
  assign w_relX      = w_x - 32'(INNER_X);
  assign w_relY      = w_y - 32'(INNER_Y);
  assign w_active    = (w_x < H_ACTIVE) && (w_y < V_ACTIVE);
  assign w_hSyncN    = !((w_x >= H_ACTIVE + H_FP) && (w_x < H_ACTIVE + H_FP + H_SYNC));
  assign w_vSyncN    = !((w_y >= V_ACTIVE + V_FP) && (w_y < V_ACTIVE + V_FP + V_SYNC));
  assign frame_start = (r_hCnt == '0) && (r_vCnt == VW'(V_ACTIVE));

  // The leftmost glyph slot holds the most significant digit.
  assign w_digIdx   = 4'(NUM_DIGITS - 1 - (w_relX >> (3 + SCALE_LOG2)));
  assign w_glyphCol = 3'(w_relX >> SCALE_LOG2);
  assign w_glyphRow = 3'(w_relY >> SCALE_LOG2);

  always_comb begin
    w_region = REG_BG;
    if ((w_x >= INNER_X) && (w_x < INNER_X1) && (w_y >= INNER_Y) && (w_y < INNER_Y1)) begin
      w_region = REG_GLYPH;
    end else if ((w_x >= BOX_X) && (w_x < OUTER_X1) && (w_y >= BOX_Y) && (w_y < OUTER_Y1)) begin
      w_region = REG_BORDER;
    end
  end

`ifdef VGA_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] r_frameCnt;
  logic          r_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frameCnt <= '0;
      r_phase    <= 1'b0;
    end else if (frame_start) begin
      if (r_frameCnt == BW'(BLINK_FRAMES - 1)) begin
        r_frameCnt <= '0;
        r_phase    <= !r_phase;
      end else begin
        r_frameCnt <= r_frameCnt + BW'(1);
      end
    end
  end

  assign w_blank = r_phase && (cursor_idx == w_digIdx) && (32'(cursor_idx) < NUM_DIGITS);
`else
  logic w_unusedBlink;
  assign w_unusedBlink = ^{cursor_idx, 32'(BLINK_FRAMES)};
  assign w_blank       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_region1 <= REG_BG;
      r_digIdx1 <= '0;
      r_row1    <= '0;
      r_col1    <= '0;
      r_blank1  <= 1'b0;
      r_active1 <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
    end else begin
      r_region1 <= w_region;
      r_digIdx1 <= w_digIdx;
      r_row1    <= w_glyphRow;
      r_col1    <= w_glyphCol;
      r_blank1  <= w_blank;
      r_active1 <= w_active;
      r_hs1     <= w_hSyncN;
      r_vs1     <= w_vSyncN;
    end
  end

  assign w_code    = r_shown[4*r_digIdx1 +: 4];
  assign w_rowBits = fontRow(w_code, r_row1);
  assign w_pixel   = w_rowBits[~r_col1];

  always_comb begin
    w_colour = BG_RGB;
    if (r_region1 == REG_BORDER) begin
      w_colour = FG_RGB;
    end else if ((r_region1 == REG_GLYPH) && w_pixel && !r_blank1) begin
      w_colour = FG_RGB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb <= '0;
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
    end else begin
      r_rgb <= r_active1 ? w_colour : 12'h000;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
    end
  end

  assign out_R = r_rgb[11:8];
  assign out_G = r_rgb[7:4];
  assign out_B = r_rgb[3:0];
  assign Hsync = r_hs2;
  assign Vsync = r_vs2;

  // New digits only reach the shown register at the start of vertical blank, so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_pendData <= '0;
      r_shown    <= {NUM_DIGITS{4'hF}};
    end else if (frame_start && r_pending) begin
      r_shown   <= r_pendData;
      r_pending <= 1'b0;
    end else if (digit_valid && !r_pending) begin
      r_pendData <= digit_data;
      r_pending  <= 1'b1;
    end
  end

  assign digit_ready = !r_pending;

endmodule

// File: tb/tb_vga_digit_display.sv
// tb_vga_digit_display: directed checks of timing, layout, glyph pixels and the frame-synchronous digit handshake.
// Uses a shrunken raster (48x24 clocks per frame) so several frames fit in a short run.
module tb_vga_digit_display;

  localparam int          H_TOT = 48;
  localparam int          FRAME = 48 * 24;
  localparam logic [11:0] FG    = 12'hFA5;
  localparam logic [11:0] BG    = 12'h123;
  localparam logic [11:0] ZERO  = 12'h000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] digit_data = 8'h00;
  logic       digit_valid = 1'b0;
  logic       digit_ready;
  logic [3:0] cursor_idx = 4'hF;
  logic [3:0] out_R;
  logic [3:0] out_G;
  logic [3:0] out_B;
  logic       Hsync;
  logic       Vsync;
  logic       frame_start;

  int testsRun = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          x;
    int          y;
    int          frame;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } pixVec_t;

  pixVec_t vecs[$];

  vga_digit_display #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(20), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .NUM_DIGITS(2), .SCALE_LOG2(1),
    .BOX_X(2), .BOX_Y(1), .BORDER(1),
    .FG_RGB(FG), .BG_RGB(BG),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digit_data(digit_data),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .cursor_idx(cursor_idx),
    .out_R(out_R),
    .out_G(out_G),
    .out_B(out_B),
    .Hsync(Hsync),
    .Vsync(Vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Independent cycle count since reset release; equals the raster position the DUT should be at.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d", testsRun);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic valid);
    digit_data  = data;
    digit_valid = valid;
  endtask

  task automatic atCycle(input int target);
    if (cyc > target) checkOutput("schedule", 16'(cyc), 16'(target));
    while (cyc < target) @(negedge clk);
  endtask

  task automatic addVec(input int x, input int y, input int f, input logic [11:0] rgb,
                        input logic hs, input logic vs);
    pixVec_t v;
    v.x = x; v.y = y; v.frame = f; v.rgb = rgb; v.hs = hs; v.vs = vs;
    vecs.push_back(v);
  endtask

  task automatic checkPixel(input int x, input int y, input int f, input logic [11:0] rgb,
                            input logic hs, input logic vs);
    atCycle(f * FRAME + y * H_TOT + x + 2);
    checkOutput($sformatf("pix(%0d,%0d)f%0d", x, y, f),
                {2'b00, out_R, out_G, out_B, Hsync, Vsync}, {2'b00, rgb, hs, vs});
  endtask

  task automatic checkResetState(input string name);
    checkOutput(name, {out_R, out_G, out_B, Hsync, Vsync, digit_ready, frame_start},
                {12'h000, 1'b1, 1'b1, 1'b1, 1'b0});
  endtask

  initial begin
    // Frame 0: nothing loaded, glyphs blank, border drawn; sync edges on line 5.
    addVec(0, 0, 0, BG, 1, 1);
    addVec(20, 1, 0, FG, 1, 1);
    addVec(9, 4, 0, BG, 1, 1);
    addVec(23, 4, 0, BG, 1, 1);
    addVec(41, 5, 0, ZERO, 1, 1);
    addVec(42, 5, 0, ZERO, 0, 1);
    addVec(45, 5, 0, ZERO, 0, 1);
    addVec(46, 5, 0, ZERO, 1, 1);
    addVec(21, 6, 0, BG, 1, 1);
    addVec(5, 8, 0, BG, 1, 1);
    addVec(2, 10, 0, FG, 1, 1);
    addVec(35, 10, 0, FG, 1, 1);
    addVec(36, 10, 0, BG, 1, 1);
    // Frame 1 shows 8'hA1: '-' on the left, '1' on the right; vertical blank checks.
    addVec(5, 2, 1, BG, 1, 1);
    addVec(25, 2, 1, FG, 1, 1);
    addVec(9, 4, 1, BG, 1, 1);
    addVec(23, 4, 1, FG, 1, 1);
    addVec(21, 6, 1, BG, 1, 1);
    addVec(3, 8, 1, BG, 1, 1);
    addVec(5, 8, 1, FG, 1, 1);
    addVec(16, 9, 1, FG, 1, 1);
    addVec(17, 9, 1, BG, 1, 1);
    addVec(25, 16, 1, BG, 1, 1);
    addVec(20, 18, 1, FG, 1, 1);
    addVec(10, 20, 1, ZERO, 1, 1);
    addVec(47, 20, 1, ZERO, 1, 1);
    addVec(0, 21, 1, ZERO, 1, 0);
    addVec(10, 22, 1, ZERO, 1, 0);
    addVec(0, 23, 1, ZERO, 1, 1);
    // Frames 2..5 show 8'hB0, 8'h3C, 8'h3C, 8'h07.
    addVec(9, 4, 2, FG, 1, 1);  addVec(23, 4, 2, FG, 1, 1);
    addVec(21, 6, 2, FG, 1, 1); addVec(5, 8, 2, FG, 1, 1);
    addVec(9, 4, 3, BG, 1, 1);  addVec(23, 4, 3, FG, 1, 1);
    addVec(21, 6, 3, BG, 1, 1); addVec(5, 8, 3, BG, 1, 1);
    addVec(9, 4, 4, BG, 1, 1);  addVec(23, 4, 4, FG, 1, 1);
    addVec(21, 6, 4, BG, 1, 1); addVec(5, 8, 4, BG, 1, 1);
    addVec(9, 4, 5, BG, 1, 1);  addVec(23, 4, 5, BG, 1, 1);
    addVec(21, 6, 5, BG, 1, 1); addVec(5, 8, 5, FG, 1, 1);

    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkResetState($sformatf("reset_c%0d", i));
    end
    rst = 1'b0;

    fork
      begin
        foreach (vecs[i]) checkPixel(vecs[i].x, vecs[i].y, vecs[i].frame, vecs[i].rgb, vecs[i].hs, vecs[i].vs);
      end
      begin
        atCycle(19 * H_TOT + 5);
        checkOutput("ready_idle", 16'(digit_ready), 16'd1);
        applyStimulus(8'hA1, 1'b1);
        @(negedge clk);
        checkOutput("ready_drop", 16'(digit_ready), 16'd0);
        applyStimulus(8'h00, 1'b0);
        atCycle(20 * H_TOT);
        checkOutput("fs_pulse", {15'd0, frame_start}, 16'd1);
        checkOutput("ready_at_fs", 16'(digit_ready), 16'd0);
        @(negedge clk);
        checkOutput("fs_one_cycle", {15'd0, frame_start}, 16'd0);
        checkOutput("ready_rise", 16'(digit_ready), 16'd1);

        atCycle(FRAME + 19 * H_TOT + 5);
        applyStimulus(8'hB0, 1'b1);
        @(negedge clk);
        checkOutput("ready_b2b_drop", 16'(digit_ready), 16'd0);
        applyStimulus(8'h3C, 1'b1);
        atCycle(FRAME + 20 * H_TOT);
        checkOutput("hold_fs_ready", {15'd0, digit_ready}, 16'd0);
        checkOutput("hold_fs_pulse", {15'd0, frame_start}, 16'd1);
        @(negedge clk);
        checkOutput("hold_ready_rise", 16'(digit_ready), 16'd1);
        @(negedge clk);
        checkOutput("hold_accept", 16'(digit_ready), 16'd0);
        applyStimulus(8'h00, 1'b0);

        atCycle(3 * FRAME + 20 * H_TOT);
        checkOutput("coinc_fs", {14'd0, frame_start, digit_ready}, 16'd3);
        applyStimulus(8'h07, 1'b1);
        @(negedge clk);
        checkOutput("coinc_accept", 16'(digit_ready), 16'd0);
        applyStimulus(8'h00, 1'b0);
        atCycle(4 * FRAME + 20 * H_TOT + 1);
        checkOutput("coinc_release", 16'(digit_ready), 16'd1);
      end
    join

    // Mid-frame reset while Hsync is low and data is pending: everything returns to reset values.
    atCycle(5 * FRAME + 15 * H_TOT + 3);
    applyStimulus(8'hBB, 1'b1);
    @(negedge clk);
    checkOutput("mid_pending", 16'(digit_ready), 16'd0);
    applyStimulus(8'h00, 1'b0);
    atCycle(5 * FRAME + 15 * H_TOT + 44);
    checkOutput("hs_before_rst", 16'(Hsync), 16'd0);
    rst = 1'b1;
    #1;
    checkResetState("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkPixel(5, 8, 0, BG, 1, 1);
    checkPixel(2, 10, 0, FG, 1, 1);
    checkPixel(9, 4, 1, BG, 1, 1);
    checkPixel(5, 8, 1, BG, 1, 1);

`ifdef VGA_BLINK_EN
    // Cursor on the rightmost glyph: visible frames 0-1, blank 2-3, visible 4-5, blank 6.
    cursor_idx = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    atCycle(19 * H_TOT + 5);
    applyStimulus(8'h01, 1'b1);
    @(negedge clk);
    applyStimulus(8'h00, 1'b0);
    checkPixel(23, 4, 1, FG, 1, 1);
    checkPixel(23, 4, 2, BG, 1, 1);
    checkPixel(5, 8, 2, FG, 1, 1);
    checkPixel(23, 4, 3, BG, 1, 1);
    checkPixel(23, 4, 4, FG, 1, 1);
    checkPixel(23, 4, 5, FG, 1, 1);
    checkPixel(23, 4, 6, BG, 1, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
